// File: rtl/exec_stub_pkg.sv
// Shared PDP8 definitions for the exec_stub execution-unit stand-in.
// Holds the decoded-opcode structs the IFD hands to the exec stage, the
// default address width, the next-PC mode and FSM state enums, and the
// "is this a valid instruction" helper functions.
package exec_stub_pkg;

    localparam int PDP_ADDR_WIDTH = 12;

    // One-hot memory-reference opcode from the IFD.
    typedef struct packed {
        logic AND;
        logic TAD;
        logic ISZ;
        logic DCA;
        logic JMS;
        logic JMP;
    } pdp_mem_opcode_s;

    // Operate-group (op7) micro-op flags from the IFD.
    typedef struct packed {
        logic NOP;
        logic IAC;
        logic RAL;
        logic RTL;
        logic RAR;
        logic RTR;
        logic CML;
        logic CMA;
        logic CIA;
        logic CLL;
        logic CLA1;
        logic CLA2;
        logic HLT;
        logic OSR;
        logic SKP;
        logic SNL;
        logic SZL;
        logic SZA;
        logic SNA;
        logic SMA;
        logic SPA;
    } pdp_op7_opcode_s;

    // Encoding 2'd3 is reserved and treated as SEQ.
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_RANDOM = 2'd2
    } exec_pc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_HALT    = 2'd3
    } exec_state_e;

    function automatic logic isMemType(input pdp_mem_opcode_s op);
        return |op;
    endfunction

    function automatic logic isOp7Type(input pdp_op7_opcode_s op);
        return |op;
    endfunction

endpackage

// File: rtl/exec_stub_lfsr16.sv
// 16-bit right-shifting Galois LFSR, free running every cycle.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset, loads the seed
//   state  out  current 16-bit LFSR state
// A zero seed would lock the register at zero, so it is replaced by 1.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] MASK = 16'hB400
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state_reg;
    logic [15:0] state_next;

    always_comb begin
        state_next = {1'b0, state_reg[15:1]};
        if (state_reg[0]) begin
            state_next = state_next ^ MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SEED_EFF;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/exec_stub.sv
// Execution-unit stand-in for unit testing the PDP8 IFD.
// Accepts a decoded instruction, holds stall for L+1 cycles, then returns a
// next PC (sequential, branch-aware or random), counts retired instructions
// and halts on HLT.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   base_addr        effective address from the IFD
//   pdp_mem_opcode   one-hot memory opcode
//   pdp_op7_opcode   op7 micro-op flags
//   pc_mode          0=SEQ 1=BRANCH 2=RANDOM 3=SEQ
//   rand_stall       1: stall length from LFSR, 0: from stall_cfg
//   stall_cfg        fixed stall length L
//   stall            high while an instruction executes or when halted
//   PC_value         next PC to the IFD
//   halted           sticky after HLT retires
//   instr_count      retired instruction count, wraps
module exec_stub
    import exec_stub_pkg::*;
#(
    parameter int                   ADDR_WIDTH = PDP_ADDR_WIDTH,
    parameter int                   MAX_STALL  = 20,
    parameter int                   STALL_W    = 5,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = 'o200,
    parameter logic [15:0]          LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  pdp_mem_opcode_s       pdp_mem_opcode,
    input  pdp_op7_opcode_s       pdp_op7_opcode,
    input  logic [1:0]            pc_mode,
    input  logic                  rand_stall,
    input  logic [STALL_W-1:0]    stall_cfg,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] PC_value,
    output logic                  halted,
    output logic [15:0]           instr_count
);

    localparam logic [STALL_W-1:0] MAX_L = STALL_W'(MAX_STALL);

    logic [15:0] lfsr_state;
    logic        lfsr_unused;

    lfsr16 #(
        .SEED (LFSR_SEED),
        .MASK (16'hB400)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr_state)
    );

    // Only the low bits feed the stall length and random PC.
    assign lfsr_unused = ^lfsr_state;

    exec_state_e           state_reg, state_next;
    logic [STALL_W-1:0]    cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic [15:0]           count_reg, count_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [1:0]            mode_reg, mode_next;
    logic                  jmp_reg, jmp_next;
    logic                  jms_reg, jms_next;
    logic                  skp_reg, skp_next;
    logic                  hlt_reg, hlt_next;

    logic                  vld;
    logic [STALL_W-1:0]    stall_src;
    logic [STALL_W-1:0]    stall_len;
    logic [ADDR_WIDTH-1:0] target_pc;

    assign vld       = isMemType(pdp_mem_opcode) | isOp7Type(pdp_op7_opcode);
    assign stall_src = rand_stall ? lfsr_state[STALL_W-1:0] : stall_cfg;
    assign stall_len = (stall_src > MAX_L) ? MAX_L : stall_src;

    // Next PC from the latched opcode and mode; the LFSR value is taken in
    // the retire cycle itself.
    always_comb begin
        target_pc = pc_reg + ADDR_WIDTH'(1);
        case (mode_reg)
            PC_BRANCH: begin
                if (jmp_reg) begin
                    target_pc = addr_reg;
                end else if (jms_reg) begin
                    target_pc = addr_reg + ADDR_WIDTH'(1);
                end else if (skp_reg) begin
                    target_pc = pc_reg + ADDR_WIDTH'(2);
                end
            end
            PC_RANDOM: target_pc = lfsr_state[ADDR_WIDTH-1:0];
            default:   target_pc = pc_reg + ADDR_WIDTH'(1);
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pc_next    = pc_reg;
        count_next = count_reg;
        addr_next  = addr_reg;
        mode_next  = mode_reg;
        jmp_next   = jmp_reg;
        jms_next   = jms_reg;
        skp_next   = skp_reg;
        hlt_next   = hlt_reg;
        stall      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (vld) begin
                    cnt_next   = stall_len;
                    addr_next  = base_addr;
                    mode_next  = pc_mode;
                    jmp_next   = pdp_mem_opcode.JMP;
                    jms_next   = pdp_mem_opcode.JMS;
                    skp_next   = pdp_op7_opcode.SKP;
                    hlt_next   = pdp_op7_opcode.HLT;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (cnt_reg == '0) begin
                    pc_next    = target_pc;
                    count_next = count_reg + 16'd1;
                    state_next = hlt_reg ? ST_HALT : ST_RELEASE;
                end else begin
                    cnt_next = cnt_reg - STALL_W'(1);
                end
            end
            // One stall-free cycle with inputs ignored so the IFD can retire
            // or replace its opcode before the next accept.
            ST_RELEASE: state_next = ST_IDLE;
            ST_HALT:    stall = 1'b1;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            pc_reg    <= RESET_PC;
            count_reg <= '0;
            addr_reg  <= '0;
            mode_reg  <= '0;
            jmp_reg   <= 1'b0;
            jms_reg   <= 1'b0;
            skp_reg   <= 1'b0;
            hlt_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
            addr_reg  <= addr_next;
            mode_reg  <= mode_next;
            jmp_reg   <= jmp_next;
            jms_reg   <= jms_next;
            skp_reg   <= skp_next;
            hlt_reg   <= hlt_next;
        end
    end

    assign PC_value    = pc_reg;
    assign instr_count = count_reg;
    assign halted      = (state_reg == ST_HALT);

endmodule

// File: doc/exec_stub.md
# exec_stub

Parametrised execution-unit stand-in for unit-level testing of the PDP8 Instruction Fetch/Decode (IFD) unit. It accepts each decoded instruction from the IFD and holds `stall` for a configurable or pseudo-random number of cycles. It then returns a next-PC computed in one of three modes: sequential, branch-aware or random. It also halts on HLT and counts the instructions it retires. It is synthesizable and sits in the IFD's position as the exec stage, driven by the IFD bench or an FPGA smoke build.

## Interface
- `ADDR_WIDTH`, 12, PC/address width.
- `MAX_STALL`, 20, upper clip on stall length L (cycles beyond the 1 minimum).
- `STALL_W`, 5, width of `stall_cfg`/stall counter; must hold `MAX_STALL`.
- `RESET_PC`, 'o200, value of `PC_value` out of reset.
- `LFSR_SEED`, 16'hACE1, LFSR reset value; 0 is replaced by 1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `base_addr`  in  ADDR_WIDTH  effective address from the IFD.
- `pdp_mem_opcode`  in  pdp_mem_opcode_s  one-hot memory opcode (AND/TAD/ISZ/DCA/JMS/JMP).
- `pdp_op7_opcode`  in  pdp_op7_opcode_s  op7 micro-op flags.
- `pc_mode`  in  2  0=SEQ, 1=BRANCH, 2=RANDOM, 3=reserved (behaves as SEQ).
- `rand_stall`  in  1  1: L from LFSR; 0: L from `stall_cfg`.
- `stall_cfg`  in  STALL_W  fixed stall length L.
- `stall`  out  1  to IFD; high while the instruction executes.
- `PC_value`  out  ADDR_WIDTH  next PC to IFD.
- `halted`  out  1  sticky after HLT.
- `instr_count`  out  16  retired instructions, wraps at 16'hFFFF->0.

## Operation
- Valid instruction (`vld`) means any `pdp_mem_opcode` bit or any `pdp_op7_opcode` flag is set.
- FSM has four states: IDLE, BUSY, RELEASE, HALT.
- **IDLE:** `stall`=0. On `vld`:
  - latch L = min(source, MAX_STALL), where source is `stall_cfg` or LFSR[STALL_W-1:0];
  - latch the opcode and `base_addr`;
  - go to BUSY.
- **BUSY:** `stall`=1. Decrement the counter each cycle. When the counter is 0 and the cycle is the last one:
  - update `PC_value`;
  - increment `instr_count`;
  - go to RELEASE, or to HALT if the latched op7 has HLT.
- **RELEASE:** `stall`=0 for one cycle and inputs are ignored, so the IFD can drop or replace its opcode. Then go to IDLE.
- **HALT:** `stall`=1 and `halted`=1 until `reset`. `PC_value` is frozen.
- **Next PC** (all arithmetic mod 2^ADDR_WIDTH):
  - SEQ: PC+1.
  - BRANCH:
    - JMP -> `base_addr`;
    - JMS -> `base_addr`+1;
    - op7 SKP -> PC+2;
    - otherwise PC+1.
  - RANDOM: LFSR[ADDR_WIDTH-1:0].
- **LFSR:** 16-bit Galois, mask 16'hB400, shifts right every cycle including HALT, reset to seed.
- `pc_mode` and `rand_stall` are sampled in the accept (IDLE) cycle only.

## Timing
- **Reset values:** `stall`=0, `PC_value`=RESET_PC, `halted`=0, `instr_count`=0, FSM=IDLE, LFSR=seed (or 1).
- **Accept:** instruction sampled at edge N (IDLE, `vld`=1). `stall` is high in cycles N+1 .. N+1+L, i.e. L+1 cycles, minimum 1.
- **Release:** new `PC_value` and `instr_count` become visible on the same edge at which `stall` falls. RELEASE occupies that cycle. The earliest next accept is the edge after it, so back-to-back throughput is one instruction per L+3 cycles.
- **`reset` asserted mid-BUSY:** next cycle shows the reset values. The pending instruction is dropped and not counted.
- **`vld` held through RELEASE:** re-accepted in the following IDLE cycle. The IFD must clear or change the opcode during RELEASE to avoid a repeat.
- **`stall_cfg` > MAX_STALL:** clipped to MAX_STALL.
- **PC wrap:** PC 'o7777 in SEQ -> 'o0000; 'o7776 + SKP -> 'o0000.

## Structure
- `pdp_mem_opcode_s`, `pdp_op7_opcode_s` and `ADDR_WIDTH` come from the existing shared PDP8 package.
- Add to the package:
  - a `exec_pc_mode_e` enum (SEQ/BRANCH/RANDOM);
  - `isMemType` and `isOp7Type` as package functions.
- One sub-module, `lfsr16` (params SEED, MASK), outputs the current state.
- The FSM, stall counter and PC logic live in `exec_stub`.

## Test plan
- **Reset + SEQ:** reset, SEQ, `stall_cfg`=3, TAD pulse -> `stall` high 4 cycles, `PC_value` 'o200->'o201, `instr_count`=1.
- **BRANCH JMP/JMS:** BRANCH, JMP with `base_addr`='o1234 -> `PC_value`='o1234; then JMS with 'o0500 -> 'o0501; then SKP at PC 'o7777 -> 'o0001.
- **Clip + rand_stall:** `stall_cfg`=31 with MAX_STALL=20 -> `stall` high exactly 21 cycles. With `rand_stall`=1 over 200 instructions, every `stall` pulse is 1..21 cycles.
- **HLT:** HLT op7 with L=0 -> `stall` rises and stays 1, `halted`=1, `instr_count` increments once. Further opcodes have no effect until `reset`.
- **Reset mid-BUSY:** `reset` during the 3rd stall cycle -> next cycle `stall`=0, `PC_value`='o200, `instr_count`=0.
- **Held `vld` + count wrap:**
  - `vld` held constant -> accepts spaced exactly L+3 cycles apart;
  - force `instr_count` near 16'hFFFF -> wraps to 0.
